// File: rtl/vta_mem_dpi_bridge_if.sv
// vta_mem_dpi_bridge_if: host burst/beat handshakes plus DPI model side.
// slave = bridge, master = memory engine and DPI memory model.
interface vta_mem_dpi_bridge_if #(
   parameter int LEN_BITS  = 8,
   parameter int ADDR_BITS = 64,
   parameter int DATA_BITS = 64
);
   logic                 host_cmd_valid;
   logic                 host_cmd_ready;
   logic                 host_cmd_opcode;
   logic [LEN_BITS-1:0]  host_cmd_len;
   logic [ADDR_BITS-1:0] host_cmd_addr;

   logic                 host_wr_valid;
   logic                 host_wr_ready;
   logic [DATA_BITS-1:0] host_wr_bits;

   logic                 host_rd_valid;
   logic                 host_rd_ready;
   logic [DATA_BITS-1:0] host_rd_bits;
   logic                 host_rd_last;

   logic                 dpi_req_valid;
   logic                 dpi_req_opcode;
   logic [LEN_BITS-1:0]  dpi_req_len;
   logic [ADDR_BITS-1:0] dpi_req_addr;

   logic                 dpi_wr_valid;
   logic [DATA_BITS-1:0] dpi_wr_bits;

   logic                 dpi_rd_valid;
   logic [DATA_BITS-1:0] dpi_rd_bits;
   logic                 dpi_rd_ready;

   modport slave (
      input  host_cmd_valid,
      output host_cmd_ready,
      input  host_cmd_opcode,
      input  host_cmd_len,
      input  host_cmd_addr,
      input  host_wr_valid,
      output host_wr_ready,
      input  host_wr_bits,
      output host_rd_valid,
      input  host_rd_ready,
      output host_rd_bits,
      output host_rd_last,
      output dpi_req_valid,
      output dpi_req_opcode,
      output dpi_req_len,
      output dpi_req_addr,
      output dpi_wr_valid,
      output dpi_wr_bits,
      input  dpi_rd_valid,
      input  dpi_rd_bits,
      output dpi_rd_ready
   );

   modport master (
      output host_cmd_valid,
      input  host_cmd_ready,
      output host_cmd_opcode,
      output host_cmd_len,
      output host_cmd_addr,
      output host_wr_valid,
      input  host_wr_ready,
      output host_wr_bits,
      input  host_rd_valid,
      output host_rd_ready,
      input  host_rd_bits,
      input  host_rd_last,
      input  dpi_req_valid,
      input  dpi_req_opcode,
      input  dpi_req_len,
      input  dpi_req_addr,
      input  dpi_wr_valid,
      input  dpi_wr_bits,
      output dpi_rd_valid,
      output dpi_rd_bits,
      input  dpi_rd_ready
   );
endinterface

// File: rtl/vta_mem_dpi_bridge.sv
// vta_mem_dpi_bridge: turns host burst commands into a one-cycle DPI
// request, passes write beats through and buffers read beats in a FIFO.
// Ports: clock, reset (async, active-low), io (slave modport of
// vta_mem_dpi_bridge_if), busy, err_overflow (sticky until reset).
module vta_mem_dpi_bridge #(
   parameter int LEN_BITS      = 8,
   parameter int ADDR_BITS     = 64,
   parameter int DATA_BITS     = 64,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   vta_mem_dpi_bridge_if.slave        io,
   output logic                       busy,
   output logic                       err_overflow
);
   localparam int PTR_BITS = $clog2(RD_FIFO_DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;
   localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(RD_FIFO_DEPTH);
   localparam logic [CNT_BITS-1:0] LOW_CNT  = CNT_BITS'(RD_FIFO_DEPTH - 2);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WRITE,
      READ
   } state_t;

   typedef struct packed {
      logic                 last;
      logic [DATA_BITS-1:0] bits;
   } rd_beat_t;

   state_t               state;
   logic                 cmd_rdy_q;
   logic                 wr_rdy_q;
   logic                 req_valid_q;
   logic                 req_opcode_q;
   logic [LEN_BITS-1:0]  req_len_q;
   logic [ADDR_BITS-1:0] req_addr_q;
   logic [LEN_BITS-1:0]  cnt_q;

   rd_beat_t             mem [RD_FIFO_DEPTH];
   logic [PTR_BITS-1:0]  wr_ptr;
   logic [PTR_BITS-1:0]  rd_ptr;
   logic [CNT_BITS-1:0]  count;
   logic                 alive_q;
   logic                 err_q;

   logic                 cmd_hs;
   logic                 wr_hs;
   logic                 rd_beat;
   logic                 cnt_zero;
   logic                 fifo_full;
   logic                 fifo_nonempty;
   logic                 push;
   logic                 pop;
   rd_beat_t             rd_head;

   assign cmd_hs        = cmd_rdy_q & io.host_cmd_valid;
   assign wr_hs         = wr_rdy_q & io.host_wr_valid;
   assign rd_beat       = (state == READ) & io.dpi_rd_valid;
   assign cnt_zero      = (cnt_q == '0);
   assign fifo_full     = (count == FULL_CNT);
   assign fifo_nonempty = (count != '0);
   assign push          = rd_beat & ~fifo_full;
   assign pop           = fifo_nonempty & io.host_rd_ready;
   assign rd_head       = mem[rd_ptr];

   // Burst sequencer; request fields live only for the REQ cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cmd_rdy_q    <= 1'b1;
         wr_rdy_q     <= 1'b0;
         req_valid_q  <= 1'b0;
         req_opcode_q <= 1'b0;
         req_len_q    <= '0;
         req_addr_q   <= '0;
         cnt_q        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_hs) begin
                  state        <= REQ;
                  cmd_rdy_q    <= 1'b0;
                  req_valid_q  <= 1'b1;
                  req_opcode_q <= io.host_cmd_opcode;
                  req_len_q    <= io.host_cmd_len;
                  req_addr_q   <= io.host_cmd_addr;
                  cnt_q        <= io.host_cmd_len;
               end
            end
            REQ: begin
               req_valid_q  <= 1'b0;
               req_opcode_q <= 1'b0;
               req_len_q    <= '0;
               req_addr_q   <= '0;
               if (req_opcode_q) begin
                  state    <= WRITE;
                  wr_rdy_q <= 1'b1;
               end else begin
                  state <= READ;
               end
            end
            WRITE: begin
               if (wr_hs) begin
                  if (cnt_zero) begin
                     state     <= IDLE;
                     wr_rdy_q  <= 1'b0;
                     cmd_rdy_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - LEN_BITS'(1);
                  end
               end
            end
            READ: begin
               // A dropped beat still counts, so the burst always ends.
               if (io.dpi_rd_valid) begin
                  if (cnt_zero) begin
                     state     <= IDLE;
                     cmd_rdy_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - LEN_BITS'(1);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               cmd_rdy_q <= 1'b1;
               wr_rdy_q  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO storage carries no reset; occupancy is tracked by count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= '{last: cnt_zero, bits: io.dpi_rd_bits};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_q   <= 1'b0;
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
         if (rd_beat & fifo_full) begin
            err_q <= 1'b1;
         end
      end
   end

   assign io.host_cmd_ready = cmd_rdy_q;
   assign io.host_wr_ready  = wr_rdy_q;

   assign io.dpi_req_valid  = req_valid_q;
   assign io.dpi_req_opcode = req_opcode_q;
   assign io.dpi_req_len    = req_len_q;
   assign io.dpi_req_addr   = req_addr_q;

   assign io.dpi_wr_valid   = wr_rdy_q & io.host_wr_valid;
   assign io.dpi_wr_bits    = wr_rdy_q ? io.host_wr_bits : '0;

   // Two free slots: one for a beat already in the model's output
   // register, one for the beat it may launch on this ready.
   assign io.dpi_rd_ready   = alive_q & (count <= LOW_CNT);

   assign io.host_rd_valid  = fifo_nonempty;
   assign io.host_rd_bits   = fifo_nonempty ? rd_head.bits : '0;
   assign io.host_rd_last   = fifo_nonempty & rd_head.last;

   assign busy              = (state != IDLE) | fifo_nonempty;
   assign err_overflow      = err_q;
endmodule
